control_seq: RTL and testbench

Next-generation multicycle control FSM for the RV32 core. It keeps the existing FETCH1/FETCH2/DECODE/MEM/EXEC sequencing and datapath strobes, and adds the following:
- variable-latency memory handshake (mem_ready)
- optional MEM-step skipping for non-memory instructions
- optional multi-cycle M-extension step with start/done handshake
- sticky HALTED state
- illegal-opcode detection
It sits between the instruction register / comparator and the datapath: regfile, ALU, PC, memory port and muldiv unit.

---
 rtl/control_seq_pkg.sv | 44 ++++
 rtl/control_seq_decode.sv | 39 +++
 rtl/control_seq.sv | 171 +++++++++++++++++
 tb/tb_control_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_seq_pkg.sv
// Shared encodings for the multicycle control sequencer: opcodes, memory op codes,
// write-data selects and FSM state encodings.
package control_seq_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Load ops match funct3 so MEM can forward funct3 directly; LNONE uses a spare code.
    localparam logic [2:0] LB    = 3'b000;
    localparam logic [2:0] LH    = 3'b001;
    localparam logic [2:0] LW    = 3'b010;
    localparam logic [2:0] LBU   = 3'b100;
    localparam logic [2:0] LHU   = 3'b101;
    localparam logic [2:0] LNONE = 3'b111;

    localparam logic [1:0] SB    = 2'b00;
    localparam logic [1:0] SH    = 2'b01;
    localparam logic [1:0] SW    = 2'b10;
    localparam logic [1:0] SNONE = 2'b11;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_PC4 = 2'b01;
    localparam logic [1:0] WD_MD  = 2'b10;
    localparam logic [1:0] WD_MEM = 2'b11;

    typedef enum logic [2:0] {
        FETCH1 = 3'd0,
        FETCH2 = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        EXEC   = 3'd4,
        MULDIV = 3'd5,
        HALTED = 3'd6
    } state_e;

endpackage

// File: rtl/control_seq_decode.sv
// Combinational opcode classifier shared by the sequencer and hazard logic.
module control_decode
    import control_seq_pkg::*;
#(
    parameter bit M_EXT = 1'b1
) (
    input  logic [6:0] opcode,
    input  logic       bit25,
    output logic       is_legal,
    output logic       needs_mem,
    output logic       is_muldiv,
    output logic       writes_rd
);

    always_comb begin
        is_legal  = 1'b0;
        needs_mem = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP_IMM, OPC_OP: begin
                is_legal  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD: begin
                is_legal  = 1'b1;
                needs_mem = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                is_legal  = 1'b1;
                needs_mem = 1'b1;
            end
            OPC_BRANCH, OPC_SYSTEM: is_legal = 1'b1;
            default: ;
        endcase
        is_muldiv = M_EXT && (opcode == OPC_OP) && bit25;
    end

endmodule

// File: rtl/control_seq.sv
// Multicycle RV32 control FSM: fetch/decode/mem/exec sequencing with memory wait,
// optional MEM skipping, muldiv handshake, sticky halt and illegal-opcode trapping.
module control_seq #(
    parameter bit MEM_WAIT_EN  = 1'b1,
    parameter bit SKIP_MEM     = 1'b1,
    parameter bit M_EXT        = 1'b1,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       bit20,
    input  logic       bit25,
    input  logic       bit30,
    input  logic       cmp_out,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic       halt,
    output logic       illegal,
    output logic       pc_enable,
    output logic       pc_load,
    output logic       reg_re1,
    output logic       reg_re2,
    output logic       reg_we,
    output logic       alu_sel1,
    output logic       alu_sel2,
    output logic [4:0] alu_op,
    output logic       target_load,
    output logic [1:0] wd_sel,
    output logic       mem_addr_sel,
    output logic [2:0] mem_read_op,
    output logic [1:0] mem_write_op,
    output logic       inst_load,
    output logic       md_start,
    output logic [2:0] state_dbg
);
    import control_seq_pkg::*;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   md_busy_q, md_busy_d;
    logic   is_legal, needs_mem, is_muldiv, writes_rd;
    logic   is_memop, go_mem;

    control_decode #(.M_EXT(M_EXT)) u_decode (
        .opcode    (opcode),
        .bit25     (bit25),
        .is_legal  (is_legal),
        .needs_mem (needs_mem),
        .is_muldiv (is_muldiv),
        .writes_rd (writes_rd)
    );

    assign is_memop = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign go_mem   = !SKIP_MEM || needs_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH1;
            illegal_q <= 1'b0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            md_busy_q <= md_busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        md_busy_d    = 1'b0;
        pc_enable    = 1'b0;
        pc_load      = 1'b0;
        reg_re1      = 1'b0;
        reg_re2      = 1'b0;
        reg_we       = 1'b0;
        alu_sel1     = 1'b0;
        alu_sel2     = 1'b0;
        alu_op       = '0;
        target_load  = 1'b0;
        wd_sel       = WD_ALU;
        mem_addr_sel = 1'b0;
        mem_read_op  = LNONE;
        mem_write_op = SNONE;
        inst_load    = 1'b0;
        md_start     = 1'b0;
        case (state_q)
            FETCH1: begin
                mem_read_op = LW;
                if (mem_ready || !MEM_WAIT_EN) state_d = FETCH2;
            end
            FETCH2: begin
                inst_load = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                reg_re1     = 1'b1;
                reg_re2     = 1'b1;
                target_load = 1'b1;
                alu_sel1    = 1'b1;
                alu_sel2    = 1'b1;
                if (!is_legal && ILLEGAL_HALT) begin
                    state_d   = HALTED;
                    illegal_d = 1'b1;
                end else if (go_mem)   state_d = MEM;
                else if (is_muldiv)    state_d = MULDIV;
                else                   state_d = EXEC;
            end
            MEM: begin
                mem_addr_sel = 1'b1;
                alu_sel2     = 1'b1;
                if (opcode == OPC_LOAD)  mem_read_op  = funct3;
                if (opcode == OPC_STORE) mem_write_op = funct3[1:0];
                if (opcode == OPC_JALR)  target_load  = 1'b1;
                if (!(is_memop && MEM_WAIT_EN && !mem_ready))
                    state_d = is_muldiv ? MULDIV : EXEC;
            end
            MULDIV: begin
                // md_busy marks "start already issued" and drops whenever we leave.
                md_start  = !md_busy_q;
                md_busy_d = !md_done;
                if (md_done) state_d = EXEC;
            end
            EXEC: begin
                reg_we  = writes_rd;
                pc_load = (opcode == OPC_BRANCH && cmp_out) || (opcode == OPC_JAL)
                          || (opcode == OPC_JALR);
                if (opcode == OPC_SYSTEM && bit20) begin
                    state_d = HALTED;
                end else begin
                    pc_enable = 1'b1;
                    state_d   = FETCH1;
                end
                if (opcode == OPC_JAL || opcode == OPC_JALR) wd_sel = WD_PC4;
                else if (opcode == OPC_LOAD)                 wd_sel = WD_MEM;
                else if (is_muldiv)                          wd_sel = WD_MD;
                if (opcode == OPC_AUIPC) begin
                    alu_sel1 = 1'b1;
                    alu_sel2 = 1'b1;
                end else if (opcode == OPC_OP_IMM || opcode == OPC_LUI) begin
                    alu_sel2 = 1'b1;
                end
                if (opcode == OPC_OP || (opcode == OPC_OP_IMM && funct3 == 3'b101))
                    alu_op = {1'b0, bit30, funct3};
                else if (opcode == OPC_OP_IMM) alu_op = {2'b00, funct3};
                else if (opcode == OPC_BRANCH) alu_op = {2'b10, funct3};
            end
            HALTED: ;
            default: state_d = FETCH1;
        endcase
        if (reset) begin
            pc_enable    = 1'b0;
            pc_load      = 1'b0;
            reg_we       = 1'b0;
            inst_load    = 1'b0;
            target_load  = 1'b0;
            md_start     = 1'b0;
            reg_re1      = 1'b0;
            reg_re2      = 1'b0;
            mem_read_op  = LNONE;
            mem_write_op = SNONE;
        end
    end

    assign halt      = (state_q == HALTED);
    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed scoreboard bench for control_seq: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the two DUT instances.
module tb_control_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       bit20 = 1'b0, bit25 = 1'b0, bit30 = 1'b0;
    logic       cmp_out = 1'b0, mem_ready = 1'b1, md_done = 1'b0;

    logic       halt, illegal, pc_enable, pc_load, reg_re1, reg_re2, reg_we;
    logic       alu_sel1, alu_sel2, target_load, mem_addr_sel, inst_load, md_start;
    logic [4:0] alu_op;
    logic [1:0] wd_sel, mem_write_op;
    logic [2:0] mem_read_op, state_dbg;

    logic       halt_b, illegal_b, pc_enable_b, pc_load_b, reg_re1_b, reg_re2_b, reg_we_b;
    logic       alu_sel1_b, alu_sel2_b, target_load_b, mem_addr_sel_b, inst_load_b, md_start_b;
    logic [4:0] alu_op_b;
    logic [1:0] wd_sel_b, mem_write_op_b;
    logic [2:0] mem_read_op_b, state_dbg_b;

    control_seq #(.MEM_WAIT_EN(1'b1), .SKIP_MEM(1'b1), .M_EXT(1'b1), .ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .bit20(bit20),
        .bit25(bit25), .bit30(bit30), .cmp_out(cmp_out), .mem_ready(mem_ready),
        .md_done(md_done), .halt(halt), .illegal(illegal), .pc_enable(pc_enable),
        .pc_load(pc_load), .reg_re1(reg_re1), .reg_re2(reg_re2), .reg_we(reg_we),
        .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .alu_op(alu_op),
        .target_load(target_load), .wd_sel(wd_sel), .mem_addr_sel(mem_addr_sel),
        .mem_read_op(mem_read_op), .mem_write_op(mem_write_op), .inst_load(inst_load),
        .md_start(md_start), .state_dbg(state_dbg)
    );

    control_seq #(.MEM_WAIT_EN(1'b1), .SKIP_MEM(1'b1), .M_EXT(1'b1), .ILLEGAL_HALT(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .bit20(bit20),
        .bit25(bit25), .bit30(bit30), .cmp_out(cmp_out), .mem_ready(mem_ready),
        .md_done(md_done), .halt(halt_b), .illegal(illegal_b), .pc_enable(pc_enable_b),
        .pc_load(pc_load_b), .reg_re1(reg_re1_b), .reg_re2(reg_re2_b), .reg_we(reg_we_b),
        .alu_sel1(alu_sel1_b), .alu_sel2(alu_sel2_b), .alu_op(alu_op_b),
        .target_load(target_load_b), .wd_sel(wd_sel_b), .mem_addr_sel(mem_addr_sel_b),
        .mem_read_op(mem_read_op_b), .mem_write_op(mem_write_op_b), .inst_load(inst_load_b),
        .md_start(md_start_b), .state_dbg(state_dbg_b)
    );

    always #5 clk = ~clk;

    localparam int ST = 0, HALT = 1, ILL = 2, PCE = 3, PCL = 4, WE = 5, IL = 6, MDS = 7;
    localparam int WD = 8, AOP = 9, MRD = 10, MWR = 11, MAS = 12, TL = 13, RE1 = 14;
    localparam int AS1 = 15, AS2 = 16, RE2 = 17;
    localparam int ST_B = 20, PCE_B = 21, WE_B = 22, PCL_B = 23, STROBES_B = 24, MISC_B = 25;

    typedef struct {
        int    cyc;
        string name;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get(input int id);
        case (id)
            ST:        return int'(state_dbg);
            HALT:      return int'(halt);
            ILL:       return int'(illegal);
            PCE:       return int'(pc_enable);
            PCL:       return int'(pc_load);
            WE:        return int'(reg_we);
            IL:        return int'(inst_load);
            MDS:       return int'(md_start);
            WD:        return int'(wd_sel);
            AOP:       return int'(alu_op);
            MRD:       return int'(mem_read_op);
            MWR:       return int'(mem_write_op);
            MAS:       return int'(mem_addr_sel);
            TL:        return int'(target_load);
            RE1:       return int'(reg_re1);
            AS1:       return int'(alu_sel1);
            AS2:       return int'(alu_sel2);
            RE2:       return int'(reg_re2);
            ST_B:      return int'(state_dbg_b);
            PCE_B:     return int'(pc_enable_b);
            WE_B:      return int'(reg_we_b);
            PCL_B:     return int'(pc_load_b);
            STROBES_B: return int'({pc_enable_b, pc_load_b, reg_we_b, inst_load_b, target_load_b,
                                    md_start_b, reg_re1_b, reg_re2_b, mem_read_op_b, mem_write_op_b});
            MISC_B:    return int'({halt_b, illegal_b, alu_sel1_b, alu_sel2_b, alu_op_b,
                                    wd_sel_b, mem_addr_sel_b});
            default:   return -1;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        int   v;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            v = get(e.sig);
            checks++;
            if (v != e.val) begin
                errors++;
                $display("FAIL %s sig%0d cycle %0d: got %0d expected %0d", e.name, e.sig, cyc, v, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input string n, input int sig, input int v);
        exp_t e;
        e.cyc = cyc; e.name = n; e.sig = sig; e.val = v;
        sb.push_back(e);
    endtask

    task automatic set_inst(input logic [6:0] op, input logic [2:0] f3,
                            input logic b20, input logic b25, input logic b30);
        opcode = op; funct3 = f3; bit20 = b20; bit25 = b25; bit30 = b30;
    endtask

    initial begin
        // reset held: strobes forced off, state FETCH1
        step();
        ex("rst", ST, 0); ex("rst", MRD, 7); ex("rst", PCE, 0); ex("rst", IL, 0);
        ex("rst", ILL, 0); ex("rst", HALT, 0); ex("rst", MDS, 0); ex("rst", RE2, 0);
        ex("rst_b", STROBES_B, 31); ex("rst_b", MISC_B, 0);

        // ADDI x1, x0, imm : 0,1,2,4
        step(); reset = 1'b0; set_inst(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0);
        ex("addi.f1", ST, 0); ex("addi.f1", MRD, 2); ex("addi.f1", MAS, 0); ex("addi.f1", WE, 0);
        step(); ex("addi.f2", ST, 1); ex("addi.f2", IL, 1);
        step(); ex("addi.dec", ST, 2); ex("addi.dec", RE1, 1); ex("addi.dec", TL, 1);
        ex("addi.dec", AS1, 1); ex("addi.dec", WE, 0);
        step(); ex("addi.ex", ST, 4); ex("addi.ex", WE, 1); ex("addi.ex", PCE, 1);
        ex("addi.ex", AOP, 0); ex("addi.ex", WD, 0); ex("addi.ex", AS1, 0);
        ex("addi.ex", AS2, 1); ex("addi.ex", PCL, 0);

        // LW with one fetch wait and three MEM wait cycles
        step(); set_inst(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0); mem_ready = 1'b0;
        ex("lw.f1wait", ST, 0); ex("lw.f1wait", MRD, 2);
        step(); mem_ready = 1'b1; ex("lw.f1", ST, 0); ex("lw.f1", MRD, 2);
        step(); ex("lw.f2", ST, 1);
        step(); ex("lw.dec", ST, 2);
        step(); mem_ready = 1'b0;
        ex("lw.mem0", ST, 3); ex("lw.mem0", MRD, 2); ex("lw.mem0", MAS, 1);
        ex("lw.mem0", AS1, 0); ex("lw.mem0", AS2, 1);
        for (int i = 0; i < 2; i++) begin
            step(); ex("lw.memw", ST, 3); ex("lw.memw", MRD, 2); ex("lw.memw", MAS, 1);
        end
        step(); mem_ready = 1'b1; ex("lw.mem3", ST, 3); ex("lw.mem3", MRD, 2);
        step(); ex("lw.ex", ST, 4); ex("lw.ex", WD, 3); ex("lw.ex", WE, 1);
        ex("lw.ex", MRD, 7); ex("lw.ex", PCE, 1);

        // SW
        step(); set_inst(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0); ex("sw.f1", ST, 0);
        step(); ex("sw.f2", ST, 1);
        step(); ex("sw.dec", ST, 2);
        step(); ex("sw.mem", ST, 3); ex("sw.mem", MWR, 2); ex("sw.mem", MRD, 7); ex("sw.mem", MAS, 1);
        step(); ex("sw.ex", ST, 4); ex("sw.ex", WE, 0); ex("sw.ex", PCE, 1); ex("sw.ex", MWR, 3);

        // BEQ taken then not taken
        for (int k = 0; k < 2; k++) begin
            step(); set_inst(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0); cmp_out = (k == 0);
            ex("beq.f1", ST, 0);
            step(); step(); step();
            ex("beq.ex", ST, 4); ex("beq.ex", AOP, 16); ex("beq.ex", PCL, (k == 0) ? 1 : 0);
            ex("beq.ex", PCE, 1); ex("beq.ex", WE, 0);
        end

        // MUL, md_done in second MULDIV cycle: 6 cycles total
        step(); set_inst(7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0); cmp_out = 1'b0; md_done = 1'b0;
        ex("mul.f1", ST, 0);
        step(); step(); step();
        ex("mul.md0", ST, 5); ex("mul.md0", MDS, 1); ex("mul.md0", WE, 0);
        step(); md_done = 1'b1; ex("mul.md1", ST, 5); ex("mul.md1", MDS, 0); ex("mul.md1", WE, 0);
        step(); md_done = 1'b0;
        ex("mul.ex", ST, 4); ex("mul.ex", WD, 2); ex("mul.ex", WE, 1); ex("mul.ex", MDS, 0);

        // EBREAK -> HALTED, sticky until reset
        step(); set_inst(7'b1110011, 3'b000, 1'b1, 1'b0, 1'b0); ex("ebrk.f1", ST, 0);
        step(); step(); step();
        ex("ebrk.ex", ST, 4); ex("ebrk.ex", PCE, 0); ex("ebrk.ex", WE, 0);
        for (int i = 0; i < 10; i++) begin
            step(); ex("halted", ST, 6); ex("halted", HALT, 1); ex("halted", PCE, 0);
            ex("halted", MRD, 7);
        end
        step(); reset = 1'b1; ex("halt.rst", ST, 6); ex("halt.rst", PCE, 0);
        step(); reset = 1'b0; set_inst(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
        ex("halt.rel", ST, 0); ex("halt.rel", MRD, 2); ex("halt.rel", HALT, 0);

        // illegal opcode: instance A halts, instance B executes as NOP
        step(); ex("ill.f2", ST, 1);
        step(); ex("ill.dec", ST, 2); ex("ill.dec", ILL, 0);
        step(); ex("ill.a", ST, 6); ex("ill.a", HALT, 1); ex("ill.a", ILL, 1);
        ex("ill.b", ST_B, 4); ex("ill.b", PCE_B, 1); ex("ill.b", WE_B, 0); ex("ill.b", PCL_B, 0);
        step(); reset = 1'b1;
        ex("ill.rst", ST, 6); ex("ill.rst", ILL, 1); ex("ill.rst", PCE, 0); ex("ill.b2", ST_B, 0);
        step(); reset = 1'b0; set_inst(7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0); md_done = 1'b0;
        ex("ill.clr", ST, 0); ex("ill.clr", ILL, 0); ex("ill.clr", HALT, 0);

        // reset in the middle of MULDIV
        step(); ex("mdr.f2", ST, 1);
        step(); ex("mdr.dec", ST, 2);
        step(); ex("mdr.md0", ST, 5); ex("mdr.md0", MDS, 1);
        step(); ex("mdr.md1", ST, 5); ex("mdr.md1", MDS, 0);
        step(); reset = 1'b1; ex("mdr.rst", ST, 5); ex("mdr.rst", MDS, 0); ex("mdr.rst", WE, 0);
        step(); reset = 1'b0; set_inst(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0);
        ex("mdr.addi", ST, 0); ex("mdr.addi", MDS, 0);
        step(); ex("mdr.addi", ST, 1); ex("mdr.addi", MDS, 0);
        step(); ex("mdr.addi", ST, 2); ex("mdr.addi", MDS, 0);
        step(); ex("mdr.addi", ST, 4); ex("mdr.addi", MDS, 0); ex("mdr.addi", WE, 1);

        // next MUL starts cleanly; md_done already high in first MULDIV cycle
        step(); set_inst(7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0); md_done = 1'b1;
        ex("mul2.f1", ST, 0);
        step(); step(); step();
        ex("mul2.md", ST, 5); ex("mul2.md", MDS, 1);
        step(); ex("mul2.ex", ST, 4); ex("mul2.ex", WD, 2); ex("mul2.ex", WE, 1);
        step(); md_done = 1'b0; ex("mul2.next", ST, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
